// File: rtl/sequence_checker.sv
// Button-game round controller: captures a code sequence, replays it, then checks the player's presses.
// Optional SEQ_TIMEOUT_EN adds an inactivity timeout while waiting for presses.
module sequence_checker #(
    parameter int MAX_LEN        = 8,
    parameter int SHOW_CYCLES    = 25_000_000,
    parameter int TIMEOUT_CYCLES = 100_000_000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [3:0]                 round_len,
    input  logic [3:0]                 rand_code,
    input  logic                       btn_valid,
    input  logic [3:0]                 btn_code,
    output logic                       show_valid,
    output logic [3:0]                 show_code,
    output logic [$clog2(MAX_LEN)-1:0] step,
    output logic                       busy,
    output logic                       pass,
    output logic                       fail
);

    // state | meaning
    // IDLE  | waiting for start after reset
    // LOAD  | capturing one rand_code per cycle into the buffer
    // SHOW  | displaying buf[idx] for SHOW_CYCLES cycles
    // GAP   | blank display for SHOW_CYCLES cycles
    // INPUT | comparing presses against buf[idx]
    // PASS  | sequence entered correctly, holds until next start
    // FAIL  | wrong press or timeout, holds until next start

    localparam int IW   = $clog2(MAX_LEN);
    localparam int CMAX = (SHOW_CYCLES > TIMEOUT_CYCLES) ? SHOW_CYCLES : TIMEOUT_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [CW-1:0] SHOW_LOAD = CW'(SHOW_CYCLES - 1);
    localparam logic [CW-1:0] TO_LOAD   = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SHOW, S_GAP, S_INPUT, S_PASS, S_FAIL
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [IW-1:0]   wp_q, wp_d;
    logic [IW-1:0]   last_q, last_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      seq_buf [MAX_LEN];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            wp_q    <= '0;
            last_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wp_q    <= wp_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Buffer contents carry no meaning outside a round, so it has no reset.
    always_ff @(posedge clk) begin
        if (state_q == S_LOAD) begin
            seq_buf[wp_q] <= rand_code;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wp_d    = wp_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE, S_PASS, S_FAIL: begin
                if (start) begin
                    if (round_len == 4'd0) begin
                        last_d = '0;
                    end else if (32'(round_len) > MAX_LEN) begin
                        last_d = IW'(MAX_LEN - 1);
                    end else begin
                        last_d = IW'(32'(round_len) - 1);
                    end
                    idx_d   = '0;
                    wp_d    = '0;
                    cnt_d   = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                wp_d = wp_q + 1'b1;
                if (wp_q == last_q) begin
                    idx_d   = '0;
                    cnt_d   = SHOW_LOAD;
                    state_d = S_SHOW;
                end
            end
            S_SHOW: begin
                if (cnt_q == '0) begin
                    cnt_d   = SHOW_LOAD;
                    state_d = S_GAP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_GAP: begin
                if (cnt_q == '0) begin
                    if (idx_q == last_q) begin
                        idx_d   = '0;
                        cnt_d   = TO_LOAD;
                        state_d = S_INPUT;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        cnt_d   = SHOW_LOAD;
                        state_d = S_SHOW;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_INPUT: begin
                if (btn_valid) begin
                    if (btn_code == seq_buf[idx_q]) begin
                        if (idx_q == last_q) begin
                            state_d = S_PASS;
                        end else begin
                            idx_d = idx_q + 1'b1;
                            cnt_d = TO_LOAD;
                        end
                    end else begin
                        state_d = S_FAIL;
                    end
                end
`ifdef SEQ_TIMEOUT_EN
                else if (cnt_q == '0) begin
                    state_d = S_FAIL;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decode only flopped state, so no input reaches an output combinationally.
    assign show_valid = (state_q == S_SHOW);
    assign show_code  = (state_q == S_SHOW) ? seq_buf[idx_q] : 4'd0;
    assign step       = idx_q;
    assign busy       = (state_q == S_LOAD) || (state_q == S_SHOW) ||
                        (state_q == S_GAP)  || (state_q == S_INPUT);
    assign pass       = (state_q == S_PASS);
    assign fail       = (state_q == S_FAIL);

endmodule

// File: tb/tb_sequence_checker.sv
// Directed self-checking bench for sequence_checker with short display/timeout parameters.
module tb_sequence_checker;

    localparam int MAX_LEN = 8;
    localparam int SHOW    = 2;
    localparam int TO      = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] round_len;
    logic [3:0] rand_code;
    logic       btn_valid;
    logic [3:0] btn_code;
    logic       show_valid;
    logic [3:0] show_code;
    logic [2:0] step;
    logic       busy;
    logic       pass;
    logic       fail;

    int total  = 0;
    int passed = 0;
    int failed = 0;
    logic [3:0] pat [8];

    sequence_checker #(
        .MAX_LEN(MAX_LEN), .SHOW_CYCLES(SHOW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .round_len(round_len),
        .rand_code(rand_code), .btn_valid(btn_valid), .btn_code(btn_code),
        .show_valid(show_valid), .show_code(show_code), .step(step),
        .busy(busy), .pass(pass), .fail(fail)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_start(input logic [3:0] len);
        start     = 1'b1;
        round_len = len;
        tick();
        start = 1'b0;
    endtask

    task automatic load(input int n);
        for (int i = 0; i < n; i++) begin
            rand_code = pat[i];
            tick();
        end
        rand_code = 4'd0;
    endtask

    task automatic show_seq(input int n, input bit poke);
        for (int k = 0; k < n; k++) begin
            for (int c = 0; c < 2 * SHOW; c++) begin
                if (poke && k == 1 && c == 0) begin
                    start     = 1'b1;
                    round_len = 4'd1;
                end else begin
                    start = 1'b0;
                end
                chk("show_valid", 32'(show_valid), 32'(c < SHOW));
                chk("show_code", 32'(show_code), (c < SHOW) ? 32'(pat[k]) : 32'd0);
                chk("show_step", 32'(step), 32'(k));
                tick();
            end
        end
        start = 1'b0;
        chk("input_busy", 32'(busy), 32'd1);
        chk("input_step", 32'(step), 32'd0);
    endtask

    task automatic press(input logic [3:0] c);
        btn_valid = 1'b1;
        btn_code  = c;
        tick();
        btn_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; round_len = 4'd0; rand_code = 4'd0;
        btn_valid = 1'b0; btn_code = 4'd0;
        repeat (3) tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_show_valid", 32'(show_valid), 32'd0);
        rst = 1'b1;
        tick();
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_pass", 32'(pass), 32'd0);
        chk("idle_fail", 32'(fail), 32'd0);
        chk("idle_show_valid", 32'(show_valid), 32'd0);
        chk("idle_show_code", 32'(show_code), 32'd0);
        chk("idle_step", 32'(step), 32'd0);

        // btn_valid while idle is ignored
        press(4'd2);
        chk("idle_btn_busy", 32'(busy), 32'd0);

        // Round 1: 2,5,0 entered correctly
        pat[0] = 4'd2; pat[1] = 4'd5; pat[2] = 4'd0;
        do_start(4'd3);
        chk("load_busy", 32'(busy), 32'd1);
        chk("load_show_valid", 32'(show_valid), 32'd0);
        load(3);
        show_seq(3, 1'b0);
        press(4'd2);
        chk("r1_step1", 32'(step), 32'd1);
        press(4'd5);
        chk("r1_step2", 32'(step), 32'd2);
        chk("r1_pass_early", 32'(pass), 32'd0);
        press(4'd0);
        chk("r1_pass", 32'(pass), 32'd1);
        chk("r1_fail", 32'(fail), 32'd0);
        chk("r1_busy", 32'(busy), 32'd0);

        // Round 2: same sequence, wrong second press
        do_start(4'd3);
        chk("r2_pass_cleared", 32'(pass), 32'd0);
        chk("r2_busy", 32'(busy), 32'd1);
        load(3);
        show_seq(3, 1'b0);
        press(4'd2);
        press(4'd4);
        chk("r2_fail", 32'(fail), 32'd1);
        chk("r2_step", 32'(step), 32'd1);
        chk("r2_busy", 32'(busy), 32'd0);
        repeat (3) tick();
        press(4'd5);
        chk("r2_fail_hold", 32'(fail), 32'd1);
        chk("r2_step_frozen", 32'(step), 32'd1);

        // Round 3: round_len 0 clamps to one step; then idle in INPUT
        pat[0] = 4'd3;
        do_start(4'd0);
        chk("r3_fail_cleared", 32'(fail), 32'd0);
        load(1);
        show_seq(1, 1'b0);
`ifdef SEQ_TIMEOUT_EN
        repeat (TO - 1) tick();
        chk("to_not_yet", 32'(fail), 32'd0);
        tick();
        chk("to_fail", 32'(fail), 32'd1);
        chk("to_busy", 32'(busy), 32'd0);
`else
        repeat (TO + 10) tick();
        chk("wait_no_fail", 32'(fail), 32'd0);
        chk("wait_busy", 32'(busy), 32'd1);
        press(4'd3);
        chk("r3_pass", 32'(pass), 32'd1);
`endif

        // Round 4: round_len 12 clamps to 8; start during SHOW and during INPUT ignored
        pat[0] = 4'd3; pat[1] = 4'd0; pat[2] = 4'd5; pat[3] = 4'd1;
        pat[4] = 4'd4; pat[5] = 4'd2; pat[6] = 4'd2; pat[7] = 4'd5;
        do_start(4'd12);
        load(8);
        show_seq(8, 1'b1);
        for (int i = 0; i < 8; i++) begin
            chk("b2b_step", 32'(step), 32'(i));
            btn_valid = 1'b1;
            btn_code  = pat[i];
            start     = (i == 3);
            round_len = 4'd1;
            tick();
        end
        btn_valid = 1'b0;
        start     = 1'b0;
        chk("r4_pass", 32'(pass), 32'd1);
        chk("r4_step", 32'(step), 32'd7);
        chk("r4_busy", 32'(busy), 32'd0);

        // Round 5: reset during INPUT at step 1, then a fresh round
        pat[0] = 4'd2; pat[1] = 4'd5; pat[2] = 4'd0;
        do_start(4'd3);
        load(3);
        show_seq(3, 1'b0);
        press(4'd2);
        chk("r5_step1", 32'(step), 32'd1);
        rst = 1'b0;
        tick();
        chk("r5_rst_busy", 32'(busy), 32'd0);
        chk("r5_rst_pass", 32'(pass), 32'd0);
        chk("r5_rst_fail", 32'(fail), 32'd0);
        chk("r5_rst_show_valid", 32'(show_valid), 32'd0);
        chk("r5_rst_show_code", 32'(show_code), 32'd0);
        chk("r5_rst_step", 32'(step), 32'd0);
        rst = 1'b1;
        tick();
        pat[0] = 4'd4; pat[1] = 4'd1;
        do_start(4'd2);
        load(2);
        show_seq(2, 1'b0);
        press(4'd4);
        press(4'd1);
        chk("r5_pass", 32'(pass), 32'd1);

        // Round 6: stored code 9 must not match button 1 (full 4-bit compare)
        pat[0] = 4'd9;
        do_start(4'd1);
        load(1);
        show_seq(1, 1'b0);
        press(4'd1);
        chk("r6_fail", 32'(fail), 32'd1);
        chk("r6_pass", 32'(pass), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
